// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the load/store/branch instruction encoder.
// Kind codes, opcodes, instruction width and the pure field-packing function.
package instr_encoder_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam int WORD_W  = INSTR_W + ADDR_W;

  typedef enum logic [1:0] {
    KIND_LOAD    = 2'd0,
    KIND_STORE   = 2'd1,
    KIND_BRANCH  = 2'd2,
    KIND_ILLEGAL = 2'd3
  } kind_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Branch imm is the 12-bit field value (not a byte offset), so imm[3:0] lands in instr[11:8].
  function automatic logic [INSTR_W-1:0] encode(input kind_e kind, input logic [4:0] rd,
                                                input logic [4:0] rs1, input logic [4:0] rs2,
                                                input logic [2:0] funct3, input logic [11:0] imm);
    logic [INSTR_W-1:0] instr;
    instr = '0;
    case (kind)
      KIND_LOAD:   instr = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      KIND_STORE:  instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      KIND_BRANCH: instr = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], OPC_BRANCH};
      default:     instr = '0;
    endcase
    return instr;
  endfunction

endpackage

// File: rtl/instr_skid_buf.sv
// Two-entry in-order buffer; data visible on out_dat the cycle after push.
// in_rdy depends only on occupancy (never on out_rdy); head held while out_rdy is low.
module instr_skid_buf #(
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_dat
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push, pop;

  assign in_rdy  = (cnt_q != 2'd2);
  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    push     = in_vld && in_rdy;
    pop      = out_rdy && out_vld;
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes LOAD/STORE/BRANCH requests into 32-bit words tagged with a running address.
// Latency 1 cycle; in_ready low when the 2-entry output buffer is full or in reset.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter logic [63:0] ADDR_STEP = 64'd4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_kind,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic [63:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [63:0]        out_addr,
  output logic               err_pulse,
  output logic [31:0]        enc_count,
  output logic [31:0]        err_count
);

  logic [63:0]        addr_q, addr_d;
  logic [31:0]        enc_count_q, enc_count_d;
  logic [31:0]        err_count_q, err_count_d;
  logic               err_pulse_q, err_pulse_d;
  logic               buf_in_rdy, buf_out_vld;
  logic [WORD_W-1:0]  buf_out_dat;
  logic [WORD_W-1:0]  push_dat;
  logic               accept, illegal, push;
  logic [INSTR_W-1:0] instr;
  kind_e              kind;

  assign kind     = kind_e'(in_kind);
  assign in_ready = buf_in_rdy && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    instr       = encode(kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm[11:0]);
    // Immediate must fit a signed 12-bit field: bits 63..11 all equal.
    illegal     = (kind == KIND_ILLEGAL) || !((&in_imm[63:11]) || !(|in_imm[63:11]));
    push        = accept && !illegal;
    push_dat    = {instr, addr_q};
    addr_d      = push ? addr_q + ADDR_STEP : addr_q;
    enc_count_d = push ? enc_count_q + 32'd1 : enc_count_q;
    err_count_d = (accept && illegal) ? err_count_q + 32'd1 : err_count_q;
    err_pulse_d = accept && illegal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= BASE_ADDR;
      enc_count_q <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  instr_skid_buf #(.DATA_W(WORD_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (push),
    .in_rdy  (buf_in_rdy),
    .in_dat  (push_dat),
    .out_vld (buf_out_vld),
    .out_rdy (out_ready),
    .out_dat (buf_out_dat)
  );

  assign out_valid = buf_out_vld && !reset;
  assign out_instr = reset ? '0 : buf_out_dat[WORD_W-1:ADDR_W];
  assign out_addr  = buf_out_dat[ADDR_W-1:0];
  assign err_pulse = err_pulse_q && !reset;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule
